// File: rtl/gpu_pkg.sv
// Shared GPU memory-system definitions.
// Provides the arbiter FSM state type, the default word/address widths
// shared by the compute cores, the arbiter and the data RAM, and a helper
// that sizes core-index fields.
package gpu_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_NUM_CORES  = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  // Width of a field that holds a core index (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the compute cores, the memory arbiter and the data RAM.
// Per-core buses are flattened with core i at slice i.
//   core_req_valid/we/addr/wdata : load/store request from each core
//   core_req_ready               : arbiter can accept a request from core i
//   core_rsp_valid/rdata         : completion pulse and load data per core
//   mem_en/we/addr/wdata         : single-port RAM access
//   mem_rdata                    : RAM read data, one cycle after mem_en edge
//   busy                         : arbiter has work in progress
// Modports: slave = arbiter view, master = core/RAM environment view.
interface mem_arbiter_if
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_CORES  = DEF_NUM_CORES
);

  logic [NUM_CORES-1:0]            core_req_valid;
  logic [NUM_CORES-1:0]            core_req_we;
  logic [NUM_CORES*ADDR_WIDTH-1:0] core_req_addr;
  logic [NUM_CORES*DATA_WIDTH-1:0] core_req_wdata;
  logic [NUM_CORES-1:0]            core_req_ready;
  logic [NUM_CORES-1:0]            core_rsp_valid;
  logic [NUM_CORES*DATA_WIDTH-1:0] core_rsp_rdata;
  logic                            mem_en;
  logic                            mem_we;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            busy;

  modport slave (
    input  core_req_valid, core_req_we, core_req_addr, core_req_wdata, mem_rdata,
    output core_req_ready, core_rsp_valid, core_rsp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output core_req_valid, core_req_we, core_req_addr, core_req_wdata, mem_rdata,
    input  core_req_ready, core_rsp_valid, core_rsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   pending     : one bit per core with a request waiting
//   rr_ptr      : index that has highest priority this round
//   grant       : first pending index at or after rr_ptr (modulo NUM_CORES)
//   any_pending : at least one pending bit is set
module rr_pick
  import gpu_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int IDX_W     = idx_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] pending,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     grant,
  output logic                 any_pending
);

  // Walk from the farthest candidate back to rr_ptr so that the last hit
  // written is the nearest one, i.e. the highest-priority pending core.
  always_comb begin
    int j;
    logic [IDX_W-1:0] idx;
    grant       = '0;
    any_pending = 1'b0;
    j           = 0;
    idx         = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      idx = IDX_W'(j);
      if (pending[idx]) begin
        grant       = idx;
        any_pending = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared data-memory arbiter between the GPU compute cores and a
// single-port synchronous data RAM. Each core has one request slot; the
// slots are served one at a time in round-robin order through a
// three-state FSM (IDLE -> ACCESS -> RESP).
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mem_arbiter_if slave view (core requests/responses, RAM port, busy)
module mem_arbiter
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_CORES  = DEF_NUM_CORES
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int               IDX_W    = idx_width(NUM_CORES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  arb_state_t            state_reg;
  logic [IDX_W-1:0]      rr_ptr_reg;
  logic [IDX_W-1:0]      grant_reg;
  logic [NUM_CORES-1:0]  pending_reg;
  logic [NUM_CORES-1:0]  slot_we_reg;
  logic [ADDR_WIDTH-1:0] slot_addr_reg [NUM_CORES];
  logic [DATA_WIDTH-1:0] slot_wdata_reg [NUM_CORES];
  logic                  mem_en_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [NUM_CORES-1:0]  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg [NUM_CORES];

  logic [NUM_CORES-1:0]  accept;
  logic [ADDR_WIDTH-1:0] req_addr [NUM_CORES];
  logic [DATA_WIDTH-1:0] req_wdata [NUM_CORES];
  logic [IDX_W-1:0]      pick_grant;
  logic                  pick_any;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign req_addr[gi]  = bus.core_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_wdata[gi] = bus.core_req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign accept[gi]    = bus.core_req_valid[gi] & ~pending_reg[gi];
      // Gated by reset so every output reads 0 while reset is held.
      assign bus.core_req_ready[gi] = reset & ~pending_reg[gi];
      assign bus.core_rsp_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rsp_rdata_reg[gi];
    end
  endgenerate

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .pending     (pending_reg),
    .rr_ptr      (rr_ptr_reg),
    .grant       (pick_grant),
    .any_pending (pick_any)
  );

  // Request slots and per-core response registers. A slot can only be
  // filled while empty, so a fill and the RESP clear never coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg   <= '0;
      slot_we_reg   <= '0;
      rsp_valid_reg <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_addr_reg[i]  <= '0;
        slot_wdata_reg[i] <= '0;
        rsp_rdata_reg[i]  <= '0;
      end
    end else begin
      rsp_valid_reg <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (accept[i]) begin
          pending_reg[i]    <= 1'b1;
          slot_we_reg[i]    <= bus.core_req_we[i];
          slot_addr_reg[i]  <= req_addr[i];
          slot_wdata_reg[i] <= req_wdata[i];
        end
        if (state_reg == RESP && grant_reg == IDX_W'(i)) begin
          pending_reg[i]   <= 1'b0;
          rsp_valid_reg[i] <= 1'b1;
          // Stores leave the last load data visible to the core.
          if (!slot_we_reg[i]) rsp_rdata_reg[i] <= bus.mem_rdata;
        end
      end
    end
  end

  // Arbitration FSM with registered RAM-port outputs. mem_addr/mem_wdata
  // are only loaded on a grant so they hold between accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            grant_reg     <= pick_grant;
            mem_en_reg    <= 1'b1;
            mem_we_reg    <= slot_we_reg[pick_grant];
            mem_addr_reg  <= slot_addr_reg[pick_grant];
            mem_wdata_reg <= slot_wdata_reg[pick_grant];
            state_reg     <= ACCESS;
          end else begin
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
          end
        end
        ACCESS: begin
          mem_en_reg <= 1'b0;
          mem_we_reg <= 1'b0;
          state_reg  <= RESP;
        end
        RESP: begin
          rr_ptr_reg <= (grant_reg == LAST_IDX) ? '0 : grant_reg + IDX_W'(1);
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.mem_en         = mem_en_reg;
  assign bus.mem_we         = mem_we_reg;
  assign bus.mem_addr       = mem_addr_reg;
  assign bus.mem_wdata      = mem_wdata_reg;
  assign bus.core_rsp_valid = rsp_valid_reg;
  assign bus.busy           = (state_reg != IDLE) | (|pending_reg);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// random traffic, all compared every cycle against a transaction-timing
// reference model of the arbiter and a shadow copy of the RAM.
module tb_mem_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int NC    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CORES(NC)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CORES(NC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Data RAM attached to the arbiter's memory port.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Stimulus driven onto the core request buses.
  bit            d_valid [NC];
  bit            d_we    [NC];
  logic [AW-1:0] d_addr  [NC];
  logic [DW-1:0] d_wdata [NC];

  // Reference model: slots, one access at a time, timing in edge numbers.
  int            e;
  bit            m_pend  [NC];
  bit            m_we    [NC];
  logic [AW-1:0] m_addr  [NC];
  logic [DW-1:0] m_wdata [NC];
  int            m_hs    [NC];
  logic [DW-1:0] m_rdata [NC];
  logic [DW-1:0] m_mem   [DEPTH];
  bit            accepted [NC];
  bit            m_act;
  int            m_core, m_gedge, m_rr, m_free;
  bit            x_mem_en, x_mem_we;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;
  logic [NC-1:0] x_rsp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_pend[i]   = 1'b0;
      m_rdata[i]  = '0;
      accepted[i] = 1'b0;
    end
    m_act = 1'b0; m_rr = 0; m_free = 0;
    x_mem_en = 1'b0; x_mem_we = 1'b0; x_addr = '0; x_wdata = '0; x_rsp = '0;
  endtask

  function automatic bit model_busy();
    bit b;
    b = m_act;
    for (int i = 0; i < NC; i++) b |= m_pend[i];
    return b;
  endfunction

  // Advance the model by one rising edge: store lands one edge after the
  // grant, response two edges after it; the next grant may happen no
  // earlier than the edge after a response; handshakes need an empty slot.
  task automatic model_edge();
    bit pend_before [NC];
    bit granted;
    int c;
    e++;
    pend_before = m_pend;
    granted = 1'b0;
    x_rsp = '0;
    for (int i = 0; i < NC; i++) accepted[i] = 1'b0;
    if (m_act && e == m_gedge + 1 && m_we[m_core]) m_mem[m_addr[m_core]] = m_wdata[m_core];
    if (m_act && e == m_gedge + 2) begin
      c = m_core;
      x_rsp[c] = 1'b1;
      if (!m_we[c]) m_rdata[c] = m_mem[m_addr[c]];
      m_pend[c] = 1'b0;
      m_act = 1'b0;
      m_rr = (c + 1) % NC;
      m_free = e + 1;
      $display("txn core %0d %s addr %0d data %02h after %0d cycles", c,
               m_we[c] ? "store" : "load", m_addr[c], m_we[c] ? m_wdata[c] : m_rdata[c], e - m_hs[c]);
    end
    if (!m_act && e >= m_free) begin
      for (int k = 0; k < NC; k++) begin
        c = (m_rr + k) % NC;
        if (!granted && m_pend[c]) begin
          granted = 1'b1;
          m_core = c;
        end
      end
    end
    if (granted) begin
      m_act = 1'b1; m_gedge = e;
      x_mem_en = 1'b1; x_mem_we = m_we[m_core];
      x_addr = m_addr[m_core]; x_wdata = m_wdata[m_core];
    end else begin
      x_mem_en = 1'b0; x_mem_we = 1'b0;
    end
    for (int i = 0; i < NC; i++) begin
      if (d_valid[i] && !pend_before[i]) begin
        m_pend[i] = 1'b1; m_we[i] = d_we[i]; m_addr[i] = d_addr[i];
        m_wdata[i] = d_wdata[i]; m_hs[i] = e; accepted[i] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("mem_en", 32'(bus.mem_en), 32'(x_mem_en));
    check_val("mem_we", 32'(bus.mem_we), 32'(x_mem_we));
    check_val("mem_addr", 32'(bus.mem_addr), 32'(x_addr));
    check_val("mem_wdata", 32'(bus.mem_wdata), 32'(x_wdata));
    for (int i = 0; i < NC; i++) begin
      check_val($sformatf("rsp_valid%0d", i), 32'(bus.core_rsp_valid[i]), 32'(x_rsp[i]));
      check_val($sformatf("rsp_rdata%0d", i), 32'(bus.core_rsp_rdata[i*DW +: DW]), 32'(m_rdata[i]));
      check_val($sformatf("ready%0d", i), 32'(bus.core_req_ready[i]), 32'(reset & !m_pend[i]));
    end
    check_val("busy", 32'(bus.busy), 32'(model_busy()));
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      bus.core_req_valid[i] = d_valid[i];
      bus.core_req_we[i]    = d_we[i];
      bus.core_req_addr[i*AW +: AW]  = d_addr[i];
      bus.core_req_wdata[i*DW +: DW] = d_wdata[i];
    end
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic req(input int c, input bit we, input int addr, input int data);
    d_valid[c] = 1'b1; d_we[c] = we; d_addr[c] = AW'(addr); d_wdata[c] = DW'(data);
  endtask

  task automatic idle(input int c);
    d_valid[c] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && model_busy(); k++) step();
    check_val("drain_busy", 32'(bus.busy), 32'(0));
  endtask

  initial begin
    int t0, t1, n_f;
    bit got_rsp;
    logic [DW-1:0] v;
    e = 0;
    for (int i = 0; i < NC; i++) req(i, 1'b0, 0, 0);
    for (int i = 0; i < NC; i++) idle(i);
    drive();
    for (int i = 0; i < DEPTH; i++) begin
      v = DW'($urandom);
      ram[i] <= v;
      m_mem[i] = v;
    end
    model_reset();
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;
    #1 check_outputs();

    // Reset pulled during ACCESS drops the load with no response.
    @(negedge clk);
    req(0, 1'b0, 3, 0); step();
    idle(0); step();
    #2 reset = 1'b0; model_reset();
    #1 check_outputs();
    @(posedge clk); @(negedge clk);
    check_outputs();
    reset = 1'b1;
    #1 check_outputs();
    for (int k = 0; k < 5; k++) step();

    // Single load of a known word.
    ram[1] <= 8'h2A; m_mem[1] = 8'h2A;
    req(0, 1'b0, 1, 0); step();
    idle(0);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) check_val("single_addr", 32'(bus.mem_addr), 32'(1));
      if (k == 3) begin
        check_val("single_rsp", 32'(bus.core_rsp_valid[0]), 32'(1));
        check_val("single_rdata", 32'(bus.core_rsp_rdata[DW-1:0]), 32'h2A);
      end
    end

    // Core 1 store, then load back.
    req(1, 1'b1, 9, 8'h0F); step();
    idle(1);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) begin
        check_val("store_we", 32'(bus.mem_we), 32'(1));
        check_val("store_wdata", 32'(bus.mem_wdata), 32'h0F);
      end
      if (k == 3) begin
        check_val("store_ack", 32'(bus.core_rsp_valid[1]), 32'(1));
        check_val("store_rdata_kept", 32'(bus.core_rsp_rdata[DW +: DW]), 32'(0));
      end
    end
    req(1, 1'b0, 9, 0); step();
    idle(1);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) check_val("load_back", 32'(bus.core_rsp_rdata[DW +: DW]), 32'h0F);
    end

    // Simultaneous loads with rr_ptr at 0.
    req(0, 1'b0, 0, 0); req(1, 1'b0, 2, 0); step();
    idle(0); idle(1);
    t0 = -1; t1 = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (bus.core_rsp_valid[0]) t0 = k;
      if (bus.core_rsp_valid[1]) t1 = k;
    end
    check_val("sim_rsp0_cycle", t0, 3);
    check_val("sim_rsp1_cycle", t1, 6);

    // Fairness: both cores re-request as soon as their slot frees.
    for (int i = 0; i < NC; i++) req(i, 1'b0, $urandom_range(0, DEPTH - 1), 0);
    n_f = 0;
    for (int cyc = 0; cyc < 100 && n_f < 10; cyc++) begin
      step();
      for (int i = 0; i < NC; i++) begin
        if (bus.core_rsp_valid[i]) begin
          check_val("fair_order", i, n_f % 2);
          check_val("fair_wait_le6", 32'((e - m_hs[i]) <= 6), 32'(1));
          n_f++;
        end
        if (accepted[i]) d_addr[i] = AW'($urandom_range(0, DEPTH - 1));
      end
    end
    check_val("fair_count", n_f, 10);
    idle(0); idle(1);
    drain();

    // Back-pressure: a changed request while the slot is full is ignored.
    req(0, 1'b0, 5, 0); step();
    req(0, 1'b1, 7, 8'h55);
    got_rsp = 1'b0;
    for (int k = 1; k <= 8 && !got_rsp; k++) begin
      step();
      if (k == 1) begin
        check_val("bp_first_addr", 32'(bus.mem_addr), 32'(5));
        check_val("bp_first_we", 32'(bus.mem_we), 32'(0));
      end
      if (bus.core_rsp_valid[0]) got_rsp = 1'b1;
      else check_val("bp_ready_low", 32'(bus.core_req_ready[0]), 32'(0));
    end
    check_val("bp_rsp_seen", 32'(got_rsp), 32'(1));
    check_val("bp_ready_back", 32'(bus.core_req_ready[0]), 32'(1));
    step();
    idle(0);
    check_val("bp_latched", 32'(bus.core_req_ready[0]), 32'(0));
    step();
    check_val("bp_second_addr", 32'(bus.mem_addr), 32'(7));
    check_val("bp_second_we", 32'(bus.mem_we), 32'(1));
    check_val("bp_second_wdata", 32'(bus.mem_wdata), 32'h55);
    drain();

    // Random traffic; a request is held until the model accepts it.
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NC; i++) begin
        if (!d_valid[i] || accepted[i]) begin
          if ($urandom_range(0, 2) != 0)
            req(i, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
          else
            idle(i);
        end
      end
      step();
    end
    idle(0); idle(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
